// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: states, opcodes and datapath selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExec,
    StRwb,
    StBranch,
    StJump,
    StAddiEx,
    StAddiWb
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALU_B_REG     = 2'b00;
  localparam logic [1:0] ALU_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

  function automatic logic is_legal(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS sequencer: steps each instruction through fetch/decode/execute/memory/writeback
// with req/ack memory handshake and a retired-instruction counter.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ack,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      StFetch:  if (mem_ack) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OP_RTYPE:     state_d = StExec;
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
          OP_ADDI:      state_d = StAddiEx;
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (opcode == OP_SW) ? StMemWr : StMemRd;
      StMemRd:  if (mem_ack) state_d = StMemWb;
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWr: begin
        if (mem_ack) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExec:   state_d = StRwb;
      StAddiEx: state_d = StAddiWb;
      StRwb, StBranch, StJump, StAddiWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      default:  state_d = StFetch;
    endcase
  end

  // Moore decode; only the fetch-side IR/PC loads look at mem_ack.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PC_SRC_ALU;
    alu_op        = ALU_OP_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = ALU_B_REG;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal       = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = ALU_B_FOUR;
        ir_write  = mem_ack;
        pc_write  = mem_ack;
      end
      StDecode: begin
        alu_src_b = ALU_B_IMM_SH2;
        illegal   = !is_legal(opcode);
      end
      StMemAdr, StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
      end
      StRwb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PC_SRC_ALUOUT;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = PC_SRC_JUMP;
      end
      StAddiWb: reg_write = 1'b1;
      default: ;
    endcase
    // Reset holds every datapath control quiet regardless of the state register.
    if (!rst) begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      alu_op        = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      illegal       = 1'b0;
    end
  end

  assign retired = rst ? retired_q : '0;

endmodule
